keypad_hex_display: RTL



---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_hex_display_hex_to_seg7.sv | 30 +++
 rtl/keypad_hex_display.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad hex display slice.
//   SEG_W          - width of one seven-segment digit pattern (dp, spare, gfedcba)
//   KEY_CODE_W     - width of a key code / hex digit
//   kp_state_t     - debounce FSM state encoding
//   HEX_SEG_TABLE  - hex digit to active-high segment pattern (bit 8 dp, bit 7 spare)
package keypad_pkg;

  localparam int SEG_W      = 9;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_t;

  // Index 0 is the first element: 0 1 2 3 4 5 6 7 8 9 A b C d E F
  localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
    9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066, 9'h06D, 9'h07D, 9'h007,
    9'h07F, 9'h06F, 9'h077, 9'h07C, 9'h039, 9'h05E, 9'h079, 9'h071
  };

endpackage

// File: rtl/keypad_hex_display_hex_to_seg7.sv
// hex_to_seg7: combinational decode of one display digit.
//   code  - 4-bit hex value of the digit
//   valid - digit holds a value; when low the blank pattern is shown
//   dp    - decimal point request, ORed into bit 8
//   seg   - 9-bit pattern: bit 8 dp, bit 7 forced 0, bits 6:0 gfedcba
module hex_to_seg7
  import keypad_pkg::*;
#(
  parameter logic [SEG_W-1:0] BLANK_PAT = 9'h000
) (
  input  logic [KEY_CODE_W-1:0] code,
  input  logic                  valid,
  input  logic                  dp,
  output logic [SEG_W-1:0]      seg
);

  logic [SEG_W-1:0] base_s;

  // Select table entry or blank, then merge the decimal point
  always_comb begin
    base_s = BLANK_PAT;
    if (valid) begin
      base_s = HEX_SEG_TABLE[code];
    end else begin
      base_s = BLANK_PAT;
    end
    seg = {base_s[8] | dp, 1'b0, base_s[6:0]};
  end

endmodule

// File: rtl/keypad_hex_display.sv
// keypad_hex_display: debounced keypad entry into a multi-digit hex display.
//   clk_200hz   - 200 Hz system tick clock
//   rst_n_in    - asynchronous active-low reset
//   key_out     - keypad state, bit i low = key i pressed
//   seg_led     - DIGITS x 9-bit segment patterns, digit d at [9d+8:9d]
//   key_valid   - one-cycle pulse per accepted press
//   key_code    - code of the last accepted key, (index+1) mod 16
//   digit_count - number of valid digits held (saturates at DIGITS)
//   overflow    - sticky, set when a valid digit is shifted out
module keypad_hex_display
  import keypad_pkg::*;
#(
  parameter int               NUM_KEYS       = 16,
  parameter int               DIGITS         = 4,
  parameter int               DEBOUNCE_TICKS = 4,
  parameter int               CLEAR_EN       = 1,
  parameter int               CLEAR_IDX      = 15,
  parameter logic [SEG_W-1:0] BLANK_PAT      = 9'h000
) (
  input  logic                      clk_200hz,
  input  logic                      rst_n_in,
  input  logic [NUM_KEYS-1:0]       key_out,
  output logic [DIGITS*SEG_W-1:0]   seg_led,
  output logic                      key_valid,
  output logic [KEY_CODE_W-1:0]     key_code,
  output logic [3:0]                digit_count,
  output logic                      overflow
);

  localparam int                     CNT_W       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0]       CNT_MAX     = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]             DIGITS_C    = 4'(DIGITS);
  localparam logic [3:0]             CLEAR_IDX_C = 4'(CLEAR_IDX);
  localparam logic [NUM_KEYS-1:0]    ALL_ONES    = {NUM_KEYS{1'b1}};

  logic [NUM_KEYS-1:0]    samp_r;
  logic [NUM_KEYS-1:0]    cand_r;
  logic [NUM_KEYS-1:0]    cand_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  kp_state_t              state_r;
  kp_state_t              state_nxt_s;
  logic                   single_s;
  logic                   accept_s;
  logic [3:0]             cand_idx_s;
  logic [KEY_CODE_W-1:0]  new_code_s;
  logic                   is_clear_s;

  logic                   key_valid_r;
  logic [KEY_CODE_W-1:0]  key_code_r;
  logic [3:0]             digit_count_r;
  logic                   overflow_r;
  logic [KEY_CODE_W-1:0]  digit_code_r [DIGITS];
  logic [DIGITS-1:0]      digit_valid_r;

  assign single_s = ($countones(~samp_r) == 1);

  // Input sampling register; the FSM only ever looks at samp_r
  always_ff @(posedge clk_200hz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      samp_r <= ALL_ONES;
    end else begin
      samp_r <= key_out;
    end
  end

  // Debounce FSM state, counter and candidate registers
  always_ff @(posedge clk_200hz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      cand_r  <= ALL_ONES;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cand_r  <= cand_nxt_s;
    end
  end

  // Debounce FSM next-state logic; accept_s marks a qualified press
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cand_nxt_s  = cand_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (single_s) begin
          cand_nxt_s  = samp_r;
          cnt_nxt_s   = CNT_ONE;
          state_nxt_s = ST_DEBOUNCE;
        end else begin
          cnt_nxt_s   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (samp_r != cand_r) begin
          // release, bounce or a second key: abandon silently
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_MAX) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_HELD;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (samp_r == ALL_ONES) begin
          if (cnt_r + CNT_ONE == CNT_MAX) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Index of the low bit in the candidate (one-hot by construction)
  always_comb begin
    cand_idx_s = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!cand_r[i]) begin
        cand_idx_s = 4'(i);
      end else begin
        cand_idx_s = cand_idx_s;
      end
    end
    new_code_s = cand_idx_s + 4'd1;   // wraps, so key 15 gives code 0
    is_clear_s = (CLEAR_EN != 0) && (cand_idx_s == CLEAR_IDX_C);
  end

  // Event outputs and digit buffer update on an accepted press
  always_ff @(posedge clk_200hz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      key_valid_r   <= 1'b0;
      key_code_r    <= 4'd0;
      digit_count_r <= 4'd0;
      overflow_r    <= 1'b0;
      digit_valid_r <= '0;
      for (int d = 0; d < DIGITS; d++) begin
        digit_code_r[d] <= 4'd0;
      end
    end else begin
      key_valid_r <= accept_s;
      if (accept_s) begin
        key_code_r <= new_code_s;
        if (is_clear_s) begin
          digit_valid_r <= '0;
          digit_count_r <= 4'd0;
          overflow_r    <= 1'b0;
        end else begin
          for (int d = 1; d < DIGITS; d++) begin
            digit_code_r[d]  <= digit_code_r[d-1];
            digit_valid_r[d] <= digit_valid_r[d-1];
          end
          digit_code_r[0]  <= new_code_s;
          digit_valid_r[0] <= 1'b1;
          if (digit_valid_r[DIGITS-1]) begin
            overflow_r <= 1'b1;
          end
          if (digit_count_r != DIGITS_C) begin
            digit_count_r <= digit_count_r + 4'd1;
          end
        end
      end
    end
  end

  assign key_valid   = key_valid_r;
  assign key_code    = key_code_r;
  assign digit_count = digit_count_r;
  assign overflow    = overflow_r;

  // One decoder per digit; digit 0 shows the held-key indicator on dp
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    hex_to_seg7 #(
      .BLANK_PAT (BLANK_PAT)
    ) u_hex_to_seg7 (
      .code  (digit_code_r[g]),
      .valid (digit_valid_r[g]),
      .dp    ((g == 0) && (state_r == ST_HELD)),
      .seg   (seg_led[g*SEG_W +: SEG_W])
    );
  end

endmodule
